ball_ctl: RTL and testbench

//  Ball motion controller for the pong game: the producer of x_pos_of_ball/y_pos_of_ball consumed by

---
 rtl/game_pkg.sv | 16 +
 rtl/vga_pkg.sv | 7 +
 rtl/ball_next_pos.sv | 90 +++++++++
 rtl/ball_ctl.sv | 130 +++++++++++++
 tb/tb_ball_ctl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Pong game types: ball FSM states, direction encodings and centring helper.
package game_pkg;

  typedef enum logic [1:0] {IDLE, SERVE, MOVE, SCORED} ball_state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Top-left coordinate that centres an object of the given size on an axis of length res.
  function automatic logic [10:0] center_pos(input int unsigned res, input int unsigned size);
    return 11'((res - size) / 2);
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the VGA chain and game logic.
package vga_pkg;

  localparam int unsigned H_RES = 1024;
  localparam int unsigned V_RES = 768;

endpackage

// File: rtl/ball_next_pos.sv
// Combinational one-frame ball step: wall bounces, paddle hits and miss detection.
module ball_next_pos
  import vga_pkg::*;
  import game_pkg::*;
#(
  parameter int unsigned SIZE_OF_BALL   = 15,
  parameter int unsigned SPEED          = 4,
  parameter int unsigned PADDLE_H       = 100,
  parameter int unsigned PADDLE_W       = 10,
  parameter int unsigned PADDLE_X_LEFT  = 20,
  parameter int unsigned PADDLE_X_RIGHT = 994
) (
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  logic        i_dir_x,
  input  logic        i_dir_y,
  input  logic [10:0] i_pad_l,
  input  logic [10:0] i_pad_r,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_dir_x,
  output logic        o_dir_y,
  output logic        o_miss_l,
  output logic        o_miss_r
);

  localparam logic [11:0] SZ   = 12'(SIZE_OF_BALL);
  localparam logic [11:0] SP   = 12'(SPEED);
  localparam logic [11:0] PH   = 12'(PADDLE_H);
  localparam logic [11:0] LF   = 12'(PADDLE_X_LEFT + PADDLE_W);
  localparam logic [11:0] RF   = 12'(PADDLE_X_RIGHT);
  localparam logic [11:0] VMAX = 12'(V_RES - 1);
  localparam logic [11:0] HMAX = 12'(H_RES - 1);

  logic [11:0] w_x, w_y, w_r, w_pl, w_pr;
  logic        w_ov_l, w_ov_r;

  assign w_x    = {1'b0, i_x};
  assign w_y    = {1'b0, i_y};
  assign w_r    = w_x + SZ;
  assign w_pl   = {1'b0, i_pad_l};
  assign w_pr   = {1'b0, i_pad_r};
  assign w_ov_l = (w_y + SZ >= w_pl) && (w_y <= w_pl + PH);
  assign w_ov_r = (w_y + SZ >= w_pr) && (w_y <= w_pr + PH);

  always_comb begin
    o_y     = i_y;
    o_dir_y = i_dir_y;
    if (i_dir_y == DIR_DOWN) begin
      if (w_y + SZ + SP >= VMAX) begin
        o_y     = 11'(VMAX - SZ);
        o_dir_y = DIR_UP;
      end else begin
        o_y = 11'(w_y + SP);
      end
    end else if (w_y < SP) begin
      o_y     = '0;
      o_dir_y = DIR_DOWN;
    end else begin
      o_y = 11'(w_y - SP);
    end
  end

  always_comb begin
    o_x      = i_x;
    o_dir_x  = i_dir_x;
    o_miss_l = 1'b0;
    o_miss_r = 1'b0;
    if (i_dir_x == DIR_LEFT) begin
      if (w_x >= LF && w_x - SP <= LF && w_ov_l) begin
        o_x     = 11'(LF);
        o_dir_x = DIR_RIGHT;
      end else if (w_x < SP) begin
        o_miss_l = 1'b1;
      end else begin
        o_x = 11'(w_x - SP);
      end
    end else begin
      if (w_r <= RF && w_r + SP >= RF && w_ov_r) begin
        o_x     = 11'(RF - SZ);
        o_dir_x = DIR_LEFT;
      end else if (w_r + SP >= HMAX) begin
        o_miss_r = 1'b1;
      end else begin
        o_x = 11'(w_x + SP);
      end
    end
  end

endmodule

// File: rtl/ball_ctl.sv
// Ball motion controller: frame tick detect, serve/score FSM and registered ball position.
module ball_ctl
  import vga_pkg::*;
  import game_pkg::*;
#(
  parameter int unsigned SIZE_OF_BALL   = 15,
  parameter int unsigned SPEED          = 4,
  parameter int unsigned PADDLE_H       = 100,
  parameter int unsigned PADDLE_W       = 10,
  parameter int unsigned PADDLE_X_LEFT  = 20,
  parameter int unsigned PADDLE_X_RIGHT = 994,
  parameter int unsigned SERVE_FRAMES   = 60
) (
  input  logic        clk65MHz,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        screen_idle,
  input  logic [10:0] y_pos_left_pad,
  input  logic [10:0] y_pos_right_pad,
  output logic [10:0] x_pos_of_ball,
  output logic [10:0] y_pos_of_ball,
  output logic        point_left,
  output logic        point_right
);

  localparam int unsigned CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] CX = center_pos(H_RES, SIZE_OF_BALL);
  localparam logic [10:0] CY = center_pos(V_RES, SIZE_OF_BALL);

  ball_state_t r_state;
  logic [10:0] r_x, r_y;
  logic        r_dir_x, r_dir_y, r_vblnk_d, r_point_left, r_point_right;
  logic [CW-1:0] r_cnt;

  logic        w_tick;
  logic [10:0] w_nx, w_ny;
  logic        w_ndx, w_ndy, w_miss_l, w_miss_r;

  assign w_tick = vblnk & ~r_vblnk_d;

  ball_next_pos #(
    .SIZE_OF_BALL  (SIZE_OF_BALL),
    .SPEED         (SPEED),
    .PADDLE_H      (PADDLE_H),
    .PADDLE_W      (PADDLE_W),
    .PADDLE_X_LEFT (PADDLE_X_LEFT),
    .PADDLE_X_RIGHT(PADDLE_X_RIGHT)
  ) u_next (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_dir_x (r_dir_x),
    .i_dir_y (r_dir_y),
    .i_pad_l (y_pos_left_pad),
    .i_pad_r (y_pos_right_pad),
    .o_x     (w_nx),
    .o_y     (w_ny),
    .o_dir_x (w_ndx),
    .o_dir_y (w_ndy),
    .o_miss_l(w_miss_l),
    .o_miss_r(w_miss_r)
  );

  always_ff @(posedge clk65MHz) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_x           <= CX;
      r_y           <= CY;
      r_dir_x       <= DIR_RIGHT;
      r_dir_y       <= DIR_DOWN;
      r_cnt         <= '0;
      r_vblnk_d     <= 1'b0;
      r_point_left  <= 1'b0;
      r_point_right <= 1'b0;
    end else begin
      r_vblnk_d     <= vblnk;
      r_point_left  <= 1'b0;
      r_point_right <= 1'b0;
      if (screen_idle) begin
        r_state <= IDLE;
        r_x     <= CX;
        r_y     <= CY;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= SERVE;
            r_cnt   <= CW'(SERVE_FRAMES);
            r_x     <= CX;
            r_y     <= CY;
          end
          SERVE: begin
            if (w_tick) begin
              r_cnt <= r_cnt - CW'(1);
              if (r_cnt == CW'(1)) r_state <= MOVE;
            end
          end
          MOVE: begin
            // A miss freezes the ball; SCORED recentres it on the next clock.
            if (w_tick) begin
              if (w_miss_l) begin
                r_point_right <= 1'b1;
                r_state       <= SCORED;
              end else if (w_miss_r) begin
                r_point_left <= 1'b1;
                r_state      <= SCORED;
              end else begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_dir_x <= w_ndx;
                r_dir_y <= w_ndy;
              end
            end
          end
          SCORED: begin
            r_x     <= CX;
            r_y     <= CY;
            r_dir_x <= ~r_dir_x;
            r_cnt   <= CW'(SERVE_FRAMES);
            r_state <= SERVE;
          end
        endcase
      end
    end
  end

  assign x_pos_of_ball = r_x;
  assign y_pos_of_ball = r_y;
  assign point_left    = r_point_left;
  assign point_right   = r_point_right;

endmodule

// File: tb/tb_ball_ctl.sv
// Self-checking bench for ball_ctl: directed rally with literal checkpoints, then randomized play.
module tb_ball_ctl;

  localparam int BS = 15, SPD = 4, PH = 100, LF = 30, RF = 994;
  localparam int CXI = 504, CYI = 376, NSERVE = 60;
  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_MOVE = 2, PH_SCORED = 3;

  logic        clk65MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk = 1'b0;
  logic        screen_idle = 1'b1;
  logic [10:0] y_pos_left_pad = 11'd300;
  logic [10:0] y_pos_right_pad = 11'd600;
  logic [10:0] x_pos_of_ball, y_pos_of_ball;
  logic        point_left, point_right;

  int n_assert = 0, n_fail = 0, n_print = 0;
  int seen_pl = 0, seen_pr = 0;

  // Reference ball: position, velocity in pixels/frame, phase and frames left to serve.
  int mx = CXI, my = CYI, vx = SPD, vy = SPD, ph = PH_IDLE, serve_left = 0;
  bit prev_vb = 0, m_pl = 0, m_pr = 0, m_valid = 0;

  ball_ctl dut (
    .clk65MHz       (clk65MHz),
    .rst_n          (rst_n),
    .vblnk          (vblnk),
    .screen_idle    (screen_idle),
    .y_pos_left_pad (y_pos_left_pad),
    .y_pos_right_pad(y_pos_right_pad),
    .x_pos_of_ball  (x_pos_of_ball),
    .y_pos_of_ball  (y_pos_of_ball),
    .point_left     (point_left),
    .point_right    (point_right)
  );

  always #5 clk65MHz = ~clk65MHz;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
    end
  endtask

  task automatic model_move();
    int ny, nvy, nx, nvx, pl, pr;
    bit miss;
    pl = int'(y_pos_left_pad);
    pr = int'(y_pos_right_pad);
    miss = 0;
    nvy = vy;
    if (vy > 0) begin
      if (my + BS + SPD >= 767) begin ny = 767 - BS; nvy = -SPD; end
      else ny = my + SPD;
    end else begin
      if (my < SPD) begin ny = 0; nvy = SPD; end
      else ny = my - SPD;
    end
    nvx = vx;
    nx = mx;
    if (vx < 0) begin
      if (mx >= LF && mx - SPD <= LF && my + BS >= pl && my <= pl + PH) begin
        nx = LF; nvx = SPD;
      end else if (mx < SPD) begin
        m_pr = 1; miss = 1;
      end else nx = mx - SPD;
    end else begin
      if (mx + BS <= RF && mx + BS + SPD >= RF && my + BS >= pr && my <= pr + PH) begin
        nx = RF - BS; nvx = -SPD;
      end else if (mx + BS + SPD >= 1023) begin
        m_pl = 1; miss = 1;
      end else nx = mx + SPD;
    end
    if (miss) ph = PH_SCORED;
    else begin
      mx = nx; my = ny; vx = nvx; vy = nvy;
    end
  endtask

  always @(posedge clk65MHz) begin
    bit tick;
    m_pl = 0;
    m_pr = 0;
    m_valid = 1;
    if (!rst_n) begin
      mx = CXI; my = CYI; vx = SPD; vy = SPD; ph = PH_IDLE; serve_left = 0; prev_vb = 0;
    end else begin
      tick = vblnk && !prev_vb;
      prev_vb = vblnk;
      if (screen_idle) begin
        ph = PH_IDLE; mx = CXI; my = CYI;
      end else begin
        case (ph)
          PH_IDLE: begin ph = PH_SERVE; serve_left = NSERVE; mx = CXI; my = CYI; end
          PH_SERVE: if (tick) begin
            serve_left--;
            if (serve_left == 0) ph = PH_MOVE;
          end
          PH_MOVE: if (tick) model_move();
          default: begin
            mx = CXI; my = CYI; vx = -vx; serve_left = NSERVE; ph = PH_SERVE;
          end
        endcase
      end
    end
  end

  always @(negedge clk65MHz) begin
    if (m_valid) begin
      check("x_pos", int'(x_pos_of_ball), mx);
      check("y_pos", int'(y_pos_of_ball), my);
      check("point_left", int'(point_left), int'(m_pl));
      check("point_right", int'(point_right), int'(m_pr));
      if (point_left && point_right) check("both_pulses", 1, 0);
      seen_pl += int'(point_left);
      seen_pr += int'(point_right);
    end
  end

  task automatic cyc();
    @(posedge clk65MHz);
    #2;
  endtask

  task automatic frame(input int hi, input int lo);
    vblnk = 1'b1;
    repeat (hi) cyc();
    vblnk = 1'b0;
    repeat (lo) cyc();
  endtask

  function automatic logic [10:0] track(input int y);
    int t;
    if ($urandom_range(0, 9) == 0) return 11'($urandom_range(0, 2047));
    t = y + 20 - int'($urandom_range(0, 130));
    if (t < 0) t = 0;
    return 11'(t);
  endfunction

  initial begin
    // Reset and idle screen
    repeat (2) cyc();
    check("rst_x", int'(x_pos_of_ball), 504);
    check("rst_y", int'(y_pos_of_ball), 376);
    check("rst_pulses", int'(point_left) + int'(point_right), 0);
    rst_n = 1'b1;
    repeat (5) frame(2, 2);
    check("idle_x", int'(x_pos_of_ball), 504);
    check("idle_y", int'(y_pos_of_ball), 376);

    // Serve: 60 frames parked, then first move
    screen_idle = 1'b0;
    cyc();
    repeat (60) frame(2, 2);
    check("serve_x", int'(x_pos_of_ball), 504);
    check("serve_y", int'(y_pos_of_ball), 376);
    frame(2, 2);
    check("move1_x", int'(x_pos_of_ball), 508);
    check("move1_y", int'(y_pos_of_ball), 380);

    // Bottom wall bounce
    repeat (92) frame(2, 2);
    check("t93_x", int'(x_pos_of_ball), 876);
    check("t93_y", int'(y_pos_of_ball), 748);
    frame(2, 2);
    check("t94_y_bounce", int'(y_pos_of_ball), 752);
    frame(2, 2);
    check("t95_y_up", int'(y_pos_of_ball), 748);

    // Right paddle hit (pad at 600)
    repeat (23) frame(2, 2);
    check("t118_x", int'(x_pos_of_ball), 976);
    check("t118_y", int'(y_pos_of_ball), 656);
    frame(2, 2);
    check("t119_hit_x", int'(x_pos_of_ball), 979);
    frame(2, 2);
    check("t120_x_left", int'(x_pos_of_ball), 975);
    check("t120_y", int'(y_pos_of_ball), 648);

    // Left paddle out of reach: ball passes and right player scores once
    y_pos_left_pad = 11'd1500;
    repeat (244) frame(2, 2);
    check("miss_pr_count", seen_pr, 1);
    check("miss_pl_count", seen_pl, 0);
    check("scored_x", int'(x_pos_of_ball), 504);
    check("scored_y", int'(y_pos_of_ball), 376);
    repeat (61) frame(2, 2);
    check("reserve_x", int'(x_pos_of_ball), 508);
    check("reserve_y", int'(y_pos_of_ball), 380);

    // screen_idle on a tick cycle while moving
    vblnk = 1'b1;
    screen_idle = 1'b1;
    cyc();
    check("idle_mid_x", int'(x_pos_of_ball), 504);
    check("idle_mid_y", int'(y_pos_of_ball), 376);
    check("idle_mid_pulses", seen_pl + seen_pr, 1);
    vblnk = 1'b0;
    cyc();
    screen_idle = 1'b0;
    cyc();

    // Reset during serve
    repeat (10) frame(2, 2);
    rst_n = 1'b0;
    cyc();
    check("rst_serve_x", int'(x_pos_of_ball), 504);
    rst_n = 1'b1;

    // Randomized play
    for (int f = 0; f < 3000; f++) begin
      y_pos_left_pad = track(my);
      y_pos_right_pad = track(my);
      if ($urandom_range(0, 399) == 0) begin
        screen_idle = 1'b1;
        vblnk = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) cyc();
        screen_idle = 1'b0;
        vblnk = 1'b0;
        cyc();
      end
      if (f == 1700) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      frame($urandom_range(1, 3), $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
